// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - mode encodings, default parameters and width helper for the time base
package aclk_pkg;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_FAST   = 2'b01;
  localparam logic [1:0] MODE_TURBO  = 2'b10;

  localparam int DEF_CLK_PER_SEC  = 256;
  localparam int DEF_SEC_PER_MIN  = 60;
  localparam int DEF_MIN_PER_HOUR = 60;
  localparam int DEF_FAST_DIV     = 16;

  // Counter width for a modulus; every legal modulus is >= 2, the guard keeps width >= 1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aclk_timegen_p_if.sv
// rtl/aclk_timegen_p_if.sv - control inputs and strobe/count outputs of the time base
interface aclk_timegen_p_if #(
  parameter int SEC_W = 6,
  parameter int MIN_W = 6
);

  logic             reset_count;
  logic             enable;
  logic [1:0]       mode;
  logic             one_second;
  logic             one_minute;
  logic             one_hour;
  logic [SEC_W-1:0] sec_count;
  logic [MIN_W-1:0] min_count;

  modport master (
    output reset_count, enable, mode,
    input  one_second, one_minute, one_hour, sec_count, min_count
  );

  modport slave (
    input  reset_count, enable, mode,
    output one_second, one_minute, one_hour, sec_count, min_count
  );

endinterface

// File: rtl/aclk_modcnt.sv
// rtl/aclk_modcnt.sv - modulo-N counter with synchronous clear and registered wrap strobe
module aclk_modcnt
  import aclk_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_w(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic last;
  assign last = (cnt == W'(N - 1));

  // wrap rises on the same edge cnt returns to 0 and is dropped by clear or an idle edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (inc) begin
      cnt  <= last ? '0 : cnt + 1'b1;
      wrap <= last;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/aclk_timegen_p.sv
// rtl/aclk_timegen_p.sv - time-base generator: prescaler, seconds, turbo and minutes chain
module aclk_timegen_p
  import aclk_pkg::*;
#(
  parameter int CLK_PER_SEC  = DEF_CLK_PER_SEC,
  parameter int SEC_PER_MIN  = DEF_SEC_PER_MIN,
  parameter int MIN_PER_HOUR = DEF_MIN_PER_HOUR,
  parameter int FAST_DIV     = DEF_FAST_DIV
) (
  input logic             clk,
  input logic             reset_n,
  aclk_timegen_p_if.slave tg
);

  localparam int PRE_W = cnt_w(CLK_PER_SEC);
  localparam int SEC_W = cnt_w(SEC_PER_MIN);
  localparam int TC_W  = cnt_w(FAST_DIV);
  localparam int MIN_W = cnt_w(MIN_PER_HOUR);

  logic             run;
  logic             fast;
  logic             turbo;
  logic             sec_tick;
  logic             tc_tick;
  logic             min_tick;
  logic [PRE_W-1:0] pre;
  logic [SEC_W-1:0] sec;
  logic [TC_W-1:0]  tc;
  logic [MIN_W-1:0] mins;
  logic             pre_wrap;
  logic             sec_wrap;
  logic             tc_wrap;
  logic             min_wrap;
  logic             minute_q;

  assign run   = tg.enable & ~tg.reset_count;
  assign fast  = (tg.mode == MODE_FAST);
  assign turbo = (tg.mode == MODE_TURBO);

  // Ticks are decoded from the pre-edge counts so every stage advances on the same edge.
  assign sec_tick = run & (pre == PRE_W'(CLK_PER_SEC - 1));
  assign tc_tick  = run & turbo & (tc == TC_W'(FAST_DIV - 1));

  always_comb begin
    min_tick = sec_tick & (sec == SEC_W'(SEC_PER_MIN - 1));
    if (fast)
      min_tick = sec_tick;
    else if (turbo)
      min_tick = tc_tick;
  end

  aclk_modcnt #(.N(CLK_PER_SEC)) u_pre (
    .clk(clk), .reset_n(reset_n), .clr(tg.reset_count), .inc(run),
    .cnt(pre), .wrap(pre_wrap)
  );

  aclk_modcnt #(.N(SEC_PER_MIN)) u_sec (
    .clk(clk), .reset_n(reset_n), .clr(tg.reset_count), .inc(sec_tick),
    .cnt(sec), .wrap(sec_wrap)
  );

  // Leaving turbo parks tc at 0 so re-entry always starts a full FAST_DIV period.
  aclk_modcnt #(.N(FAST_DIV)) u_tc (
    .clk(clk), .reset_n(reset_n), .clr(tg.reset_count | ~turbo), .inc(run & turbo),
    .cnt(tc), .wrap(tc_wrap)
  );

  aclk_modcnt #(.N(MIN_PER_HOUR)) u_min (
    .clk(clk), .reset_n(reset_n), .clr(tg.reset_count), .inc(min_tick),
    .cnt(mins), .wrap(min_wrap)
  );

  logic unused_wraps;
  assign unused_wraps = &{1'b0, sec_wrap, tc_wrap};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      minute_q <= 1'b0;
    else if (tg.reset_count)
      minute_q <= 1'b0;
    else
      minute_q <= min_tick;
  end

  assign tg.one_second = pre_wrap;
  assign tg.one_minute = minute_q;
  assign tg.one_hour   = min_wrap;
  assign tg.sec_count  = sec;
  assign tg.min_count  = mins;

endmodule

// File: tb/tb_aclk_timegen_p.sv
// tb/tb_aclk_timegen_p.sv - directed self-checking bench for aclk_timegen_p
module tb_aclk_timegen_p;
  import aclk_pkg::*;

  localparam int CPS = 4;
  localparam int SPM = 3;
  localparam int MPH = 2;
  localparam int FD  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  aclk_timegen_p_if #(.SEC_W($clog2(SPM)), .MIN_W($clog2(MPH))) tg ();

  aclk_timegen_p #(
    .CLK_PER_SEC(CPS), .SEC_PER_MIN(SPM), .MIN_PER_HOUR(MPH), .FAST_DIV(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tg(tg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input bit os, input bit om, input bit oh,
                         input int sec, input int mn);
    chk({tag, ".one_second"}, 32'(tg.one_second), 32'(os));
    chk({tag, ".one_minute"}, 32'(tg.one_minute), 32'(om));
    chk({tag, ".one_hour"},   32'(tg.one_hour),   32'(oh));
    chk({tag, ".sec_count"},  32'(tg.sec_count),  32'(sec));
    chk({tag, ".min_count"},  32'(tg.min_count),  32'(mn));
  endtask

  // Reset, check the idle outputs, then release between edges: the next posedge is edge 1.
  task automatic do_reset(input string tag, input logic [1:0] m);
    reset_n = 1'b0;
    tg.reset_count = 1'b0;
    tg.enable = 1'b1;
    tg.mode = m;
    repeat (2) step();
    chk_out({tag, ".in_reset"}, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  // Expected schedule for CPS=4, SPM=3, MPH=2, FD=2, edge e counted from reset release.
  task automatic run_edges(input string tag, input logic [1:0] m, input int first, input int last);
    bit os, om, oh;
    int sec, mn;
    for (int e = first; e <= last; e++) begin
      step();
      os  = (e % 4 == 0);
      sec = (e / 4) % 3;
      case (m)
        MODE_FAST:  begin om = os;          oh = (e % 8 == 0);  mn = (e / 4) % 2;  end
        MODE_TURBO: begin om = (e % 2 == 0); oh = (e % 4 == 0); mn = (e / 2) % 2;  end
        default:    begin om = (e % 12 == 0); oh = (e % 24 == 0); mn = (e / 12) % 2; end
      endcase
      chk_out($sformatf("%s.e%0d", tag, e), os, om, oh, sec, mn);
    end
  endtask

  initial begin
    tg.reset_count = 1'b0;
    tg.enable = 1'b0;
    tg.mode = MODE_NORMAL;

    do_reset("normal", MODE_NORMAL);
    run_edges("normal", MODE_NORMAL, 1, 26);

    do_reset("mode11", 2'b11);
    run_edges("mode11", 2'b11, 1, 13);

    do_reset("fast", MODE_FAST);
    run_edges("fast", MODE_FAST, 1, 17);

    do_reset("turbo", MODE_TURBO);
    run_edges("turbo", MODE_TURBO, 1, 9);

    // Turbo to normal: mode 00 sampled at edge 5 clears tc, no turbo strobe at edge 6.
    do_reset("t2n", MODE_TURBO);
    run_edges("t2n", MODE_TURBO, 1, 4);
    tg.mode = MODE_NORMAL;
    step();
    chk_out("t2n.e5", 0, 0, 0, 1, 0);
    chk("t2n.e5.tc", 32'(dut.u_tc.cnt), 32'd0);
    step();
    chk_out("t2n.e6", 0, 0, 0, 1, 0);
    chk("t2n.e6.tc", 32'(dut.u_tc.cnt), 32'd0);
    repeat (5) step();
    chk_out("t2n.e11", 0, 0, 0, 2, 0);
    step();
    chk_out("t2n.e12", 1, 1, 0, 0, 1);

    // Pause after edge 3: pre holds at 3, then the first enabled edge produces a second.
    do_reset("pause", MODE_NORMAL);
    run_edges("pause", MODE_NORMAL, 1, 3);
    tg.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("pause.hold%0d.pre", i), 32'(dut.u_pre.cnt), 32'd3);
      chk($sformatf("pause.hold%0d.strobes", i),
          32'({tg.one_second, tg.one_minute, tg.one_hour}), 32'd0);
    end
    tg.enable = 1'b1;
    step();
    chk_out("pause.resume", 1, 0, 0, 1, 0);

    // Clear on the edge that would wrap pre, sec and min together.
    do_reset("clr", MODE_NORMAL);
    run_edges("clr", MODE_NORMAL, 1, 23);
    chk("clr.pre_before", 32'(dut.u_pre.cnt), 32'd3);
    tg.reset_count = 1'b1;
    step();
    chk_out("clr.edge", 0, 0, 0, 0, 0);
    chk("clr.pre", 32'(dut.u_pre.cnt), 32'd0);
    tg.reset_count = 1'b0;
    repeat (3) step();
    chk_out("clr.after3", 0, 0, 0, 0, 0);
    step();
    chk_out("clr.after4", 1, 0, 0, 1, 0);

    // Async reset between edges while one_minute is high.
    do_reset("async", MODE_NORMAL);
    run_edges("async", MODE_NORMAL, 1, 12);
    #1;
    reset_n = 1'b0;
    #1;
    chk_out("async.low", 0, 0, 0, 0, 0);
    step();
    chk_out("async.held", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    run_edges("async.rerun", MODE_NORMAL, 1, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
